// File: rtl/ego1_pkg.sv
// Board-level constants and shared types for the EGO1 input-conditioning blocks.
package ego1_pkg;

  localparam int unsigned SYS_CLK_HZ  = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  // Encoding is {debounced level, counting}.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    SETTLE_HI = 2'b01,
    STABLE_HI = 2'b10,
    SETTLE_LO = 2'b11
  } db_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (SYS_CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-FF synchroniser, settle counter and level FSM with
// registered one-cycle rise/fall pulses.
module sw_debounce_ch
  import ego1_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  db_state_t        r_state;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_state <= STABLE_LO;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= pin;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          if (r_sync2) begin
            r_state <= SETTLE_HI;
            r_cnt   <= CNT_ONE;
          end
        end
        SETTLE_HI: begin
          if (!r_sync2) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!r_sync2) begin
            r_state <= SETTLE_LO;
            r_cnt   <= CNT_ONE;
          end
        end
        SETTLE_LO: begin
          if (r_sync2) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The level bit of the state encoding is the debounced output itself.
  assign db   = r_state[1];
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: rtl/sw_debounce_8.sv
// Eight-channel slide-switch conditioner: independent debounced levels,
// per-channel edge pulses and a combined any-edge pulse.
module sw_debounce_8
  import ego1_pkg::*;
#(
  parameter int unsigned N_CH          = 8,
  parameter int unsigned STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic            sys_clk_in,
  input  logic            sys_rst_n,
  input  logic [N_CH-1:0] sw_pin,
  output logic [N_CH-1:0] sw_db,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_any
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sw_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk  (sys_clk_in),
      .rst_n(sys_rst_n),
      .pin  (sw_pin[g]),
      .db   (sw_db[g]),
      .rise (sw_rise[g]),
      .fall (sw_fall[g])
    );
  end

  // Pulses are already registered, so this OR adds no path from sw_pin.
  assign sw_any = |{sw_rise, sw_fall};

endmodule
